// File: rtl/nist_stim_gen_if.sv
// Control/data bundle between the NIST stimulus source and its driver/monitor.
// master drives mode/seed/start/err_in; slave (the generator) drives the bit stream and status.
interface nist_stim_gen_if #(
    parameter int CW = 15
);
    logic          start;
    logic [2:0]    mode;
    logic [15:0]   seed;
    logic          err_in;
    logic          rnd_out;
    logic          rnd_valid;
    logic          busy;
    logic          done;
    logic          err_seen;
    logic [CW-1:0] err_index;

    modport master (
        output start, mode, seed, err_in,
        input  rnd_out, rnd_valid, busy, done, err_seen, err_index
    );

    modport slave (
        input  start, mode, seed, err_in,
        output rnd_out, rnd_valid, busy, done, err_seen, err_index
    );
endinterface

// File: rtl/nist_stim_gen.sv
// NIST SP 800-22 stimulus source: one pattern bit per clock, first bit one cycle after start.
// No backpressure; NIST_STIM_HOLD_EN adds a hold input that stalls the frame bit-exactly.
module nist_stim_gen #(
    parameter int          FRAME_LEN = 20000,
    parameter int          RUN_LEN   = 32,
    parameter logic [15:0] DEF_SEED  = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef NIST_STIM_HOLD_EN
    input  logic hold,
`endif
    nist_stim_gen_if.slave bus
);
    localparam int            CW   = $clog2(FRAME_LEN);
    localparam int            RB   = $clog2(RUN_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] HALF = CW'(FRAME_LEN / 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [2:0]    mode_q;
    logic [15:0]   lfsr;
    logic [CW-1:0] cnt;
    logic          out_q, vld_q, busy_q, done_q, err_seen_q;
    logic [CW-1:0] err_idx_q;

    logic          hold_act;
    logic [15:0]   lfsr_nx, seed_eff;
    logic [CW-1:0] cnt_nx;

`ifdef NIST_STIM_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Fibonacci form, taps 16/14/13/11; the output bit is lfsr[0].
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic pat(input logic [2:0] m, input logic [15:0] lf, input logic [CW-1:0] idx);
        case (m)
            3'd1:    return 1'b0;
            3'd2:    return 1'b1;
            3'd3:    return idx[0];
            3'd4:    return lf[0] & lf[1];
            3'd5:    return idx[RB];
            3'd6:    return (idx < HALF) ? lf[0] : 1'b1;
            default: return lf[0];
        endcase
    endfunction

    assign lfsr_nx  = lfsr_step(lfsr);
    assign cnt_nx   = cnt + 1'b1;
    assign seed_eff = (bus.seed == 16'd0) ? DEF_SEED : bus.seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 3'd0;
            lfsr       <= DEF_SEED;
            cnt        <= '0;
            out_q      <= 1'b0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_seen_q <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state      <= RUN;
                    mode_q     <= bus.mode;
                    lfsr       <= seed_eff;
                    cnt        <= '0;
                    err_seen_q <= 1'b0;
                    err_idx_q  <= '0;
                    // Bit 0 is precomputed so it is on the wire the cycle after start.
                    out_q      <= pat(bus.mode, seed_eff, '0);
                    vld_q      <= 1'b1;
                    busy_q     <= 1'b1;
                end
                RUN: begin
                    if (bus.err_in && !err_seen_q) begin
                        err_seen_q <= 1'b1;
                        err_idx_q  <= (cnt == '0) ? '0 : cnt - 1'b1;
                    end
                    if (!hold_act) begin
                        lfsr <= lfsr_nx;
                        if (cnt == LAST) begin
                            state  <= DONE;
                            out_q  <= 1'b0;
                            vld_q  <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt   <= cnt_nx;
                            out_q <= pat(mode_q, lfsr_nx, cnt_nx);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rnd_out   = out_q;
    assign bus.rnd_valid = vld_q & ~hold_act;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_seen  = err_seen_q;
    assign bus.err_index = err_idx_q;
endmodule

// File: tb/tb_nist_stim_gen.sv
// Randomized directed bench for nist_stim_gen against a frame-level reference model.
module tb_nist_stim_gen;
    localparam int FL  = 20000;
    localparam int RL  = 32;
    localparam int CW  = $clog2(FL);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    nist_stim_gen_if #(.CW(CW)) bus();

`ifdef NIST_STIM_HOLD_EN
    logic hold = 1'b0;
    nist_stim_gen #(.FRAME_LEN(FL), .RUN_LEN(RL)) dut (.clk(clk), .rst_n(rst_n), .hold(hold), .bus(bus));
`else
    nist_stim_gen #(.FRAME_LEN(FL), .RUN_LEN(RL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lfsr_adv(input int l);
        int fb;
        fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (fb << 15)) & 16'hFFFF;
    endfunction

    // Expected bit k of a frame given the generator word l that belongs to bit k.
    function automatic logic model_bit(input int m, input int l, input int k);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (k % 2) == 1;
            4:       return ((l & 3) == 3);
            5:       return ((k / RL) % 2) == 1;
            6:       return (k < FL / 2) ? ((l & 1) == 1) : 1'b1;
            default: return (l & 1) == 1;
        endcase
    endfunction

    task automatic start_frame(input logic [2:0] m, input logic [15:0] s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.seed  = s;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Watches one frame; stops at done, after stop_at bits, or when the cycle budget expires.
    task automatic capture(input int m, input logic [15:0] sd, input int stop_at, input int e1, input int e2,
                           output int nvalid, output int bad, output int gaps,
                           output logic [15:0] obs16, output logic saw_done);
        int l;
        l = (sd == 16'd0) ? 32'hACE1 : int'(sd);
        nvalid = 0; bad = 0; gaps = 0; obs16 = '0; saw_done = 1'b0;
        for (int c = 0; c < FL + 16; c++) begin
            @(negedge clk);
            bus.err_in = 1'b0;
            bus.start  = 1'b0;
            if (bus.done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
            if (bus.rnd_valid === 1'b1) begin
                if (bus.rnd_out !== model_bit(m, l, nvalid)) bad++;
                if (nvalid < 16) obs16[nvalid] = bus.rnd_out;
                bus.err_in = (nvalid == e1) || (nvalid == e2);
                bus.start  = (nvalid == 200);
                bus.mode   = 3'($urandom);
                bus.seed   = 16'($urandom);
                l = lfsr_adv(l);
                nvalid++;
                if (nvalid == stop_at) break;
            end else begin
                gaps++;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nv, bad, gaps;
        logic [15:0] o16, rs;
        logic sd;
        bus.start = 1'b0; bus.mode = 3'd0; bus.seed = 16'd0; bus.err_in = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst rnd_out",   32'(bus.rnd_out), 0);
        chk("rst rnd_valid", 32'(bus.rnd_valid), 0);
        chk("rst busy",      32'(bus.busy), 0);
        chk("rst done",      32'(bus.done), 0);
        chk("rst err_seen",  32'(bus.err_seen), 0);
        chk("rst err_index", 32'(bus.err_index), 0);
        rst_n = 1'b1;

        // Full all-zeros frame, then a start held only during DONE must be ignored
        start_frame(3'd1, 16'h1234);
        chk("m1 busy after start", 32'(bus.busy), 1);
        capture(1, 16'h1234, -1, -1, -1, nv, bad, gaps, o16, sd);
        chk("m1 nvalid", nv, FL);
        chk("m1 bits", bad, 0);
        chk("m1 gaps", gaps, 0);
        chk("m1 done seen", 32'(sd), 1);
        chk("m1 busy at done", 32'(bus.busy), 0);
        chk("m1 valid at done", 32'(bus.rnd_valid), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done one cycle", 32'(bus.done), 0);
        chk("start in DONE ignored", 32'(bus.busy), 0);
        @(negedge clk);
        chk("idle stays idle", 32'(bus.busy), 0);

        // PRBS from default seed and from seed 1: first 16 bits are the seed, LSB first
        start_frame(3'd0, 16'h0000);
        capture(0, 16'h0000, 64, -1, -1, nv, bad, gaps, o16, sd);
        chk("m0 seed0 bits", bad, 0);
        chk("m0 seed0 first16", 32'(o16), 32'hACE1);
        pulse_reset();
        start_frame(3'd0, 16'h0001);
        capture(0, 16'h0001, 64, -1, -1, nv, bad, gaps, o16, sd);
        chk("m0 seed1 bits", bad, 0);
        chk("m0 seed1 first16", 32'(o16), 32'h0001);
        chk("m0 seed1 gaps", gaps, 0);
        pulse_reset();

        // Fixed patterns, short windows
        for (int m = 2; m <= 7; m++) begin
            if (m == 6) continue;
            rs = 16'($urandom);
            start_frame(3'(m), rs);
            capture(m, rs, 300, -1, -1, nv, bad, gaps, o16, sd);
            chk($sformatf("mode%0d bits", m), bad, 0);
            pulse_reset();
        end

        // Half-frame switch-over of mode 6
        rs = 16'($urandom);
        start_frame(3'd6, rs);
        capture(6, rs, FL / 2 + 64, -1, -1, nv, bad, gaps, o16, sd);
        chk("mode6 bits across half", bad, 0);
        chk("mode6 count", nv, FL / 2 + 64);
        pulse_reset();

        // Error capture: first rise at bit 100, later rise ignored, full frame
        rs = 16'($urandom);
        start_frame(3'd0, rs);
        capture(0, rs, -1, 100, 300, nv, bad, gaps, o16, sd);
        chk("err frame bits", bad, 0);
        chk("err frame nvalid", nv, FL);
        chk("err_seen", 32'(bus.err_seen), 1);
        chk("err_index", 32'(bus.err_index), 99);
        @(negedge clk);
        chk("err_seen holds after frame", 32'(bus.err_seen), 1);
        chk("err_index holds after frame", 32'(bus.err_index), 99);
        start_frame(3'd3, 16'h0);
        chk("err_seen cleared at start", 32'(bus.err_seen), 0);
        chk("err_index cleared at start", 32'(bus.err_index), 0);
        capture(3, 16'h0, 20, 0, -1, nv, bad, gaps, o16, sd);
        chk("err at bit0 seen", 32'(bus.err_seen), 1);
        chk("err at bit0 index saturates", 32'(bus.err_index), 0);
        pulse_reset();

        // Reset mid-frame at bit 5000, then a fresh frame restarts at index 0
        rs = 16'($urandom);
        start_frame(3'd0, rs);
        capture(0, rs, 5000, 10, -1, nv, bad, gaps, o16, sd);
        chk("pre-abort bits", bad, 0);
        rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(bus.rnd_valid), 0);
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort err_seen", 32'(bus.err_seen), 0);
        chk("abort rnd_out", 32'(bus.rnd_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no done after abort", 32'(bus.done), 0);
        start_frame(3'd5, 16'hBEEF);
        capture(5, 16'hBEEF, 100, -1, -1, nv, bad, gaps, o16, sd);
        chk("restart bits", bad, 0);
        chk("restart gaps", gaps, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
